// File: rtl/regbank_sb.sv
// Parametrised register bank with two combinational read ports, one write port and a busy scoreboard.
// Optional same-cycle write-to-read forwarding is enabled by defining REGBANK_BYPASS_EN.
module regbank_sb #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NREGS    = 32,
  parameter bit          ZERO_REG = 1'b1,
  localparam int unsigned AW      = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   rs1_addr_i,
  input  logic [AW-1:0]   rs2_addr_i,
  output logic [XLEN-1:0] rs1_data_o,
  output logic [XLEN-1:0] rs2_data_o,
  output logic            rs1_busy_o,
  output logic            rs2_busy_o,
  input  logic            wr_en_i,
  input  logic [AW-1:0]   rd_addr_i,
  input  logic [XLEN-1:0] data_i,
  input  logic            alloc_en_i,
  input  logic [AW-1:0]   alloc_addr_i,
  output logic            alloc_ok_o,
  input  logic            flush_i,
  output logic [AW:0]     busy_count_o
);

  logic [XLEN-1:0] regs_q [NREGS];
  logic [NREGS-1:0] busy_q, busy_d;
  logic [AW:0]      count_q, count_d;

  logic wr_zero, alloc_zero, wr_eff, alloc_set, busy_clr;

  assign wr_zero    = ZERO_REG && (rd_addr_i == '0);
  assign alloc_zero = ZERO_REG && (alloc_addr_i == '0);
  assign wr_eff     = wr_en_i && !wr_zero;

  // Acceptance uses the pre-edge busy bit, so a register being written back this cycle is refused.
  assign alloc_ok_o = alloc_zero || !busy_q[alloc_addr_i];
  assign alloc_set  = alloc_en_i && alloc_ok_o && !alloc_zero && !flush_i;
  assign busy_clr   = wr_eff && busy_q[rd_addr_i] &&
                      !(alloc_set && (alloc_addr_i == rd_addr_i));

  always_comb begin
    busy_d = busy_q;
    if (wr_eff) busy_d[rd_addr_i] = 1'b0;
    if (alloc_set) busy_d[alloc_addr_i] = 1'b1;
    if (flush_i) busy_d = '0;
  end

  always_comb begin
    if (flush_i) count_d = '0;
    else count_d = count_q + (AW+1)'(alloc_set) - (AW+1)'(busy_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      busy_q  <= '0;
      count_q <= '0;
    end else begin
      if (wr_eff) regs_q[rd_addr_i] <= data_i;
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  assign busy_count_o = count_q;

  logic [AW-1:0]   rs_addr [2];
  logic [XLEN-1:0] rs_data [2];
  logic            rs_busy [2];

  assign rs_addr[0] = rs1_addr_i;
  assign rs_addr[1] = rs2_addr_i;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rs_data[p] = regs_q[rs_addr[p]];
      rs_busy[p] = busy_q[rs_addr[p]];
`ifdef REGBANK_BYPASS_EN
      if (wr_eff && (rd_addr_i == rs_addr[p])) begin
        rs_data[p] = data_i;
        rs_busy[p] = alloc_set && (alloc_addr_i == rs_addr[p]);
      end
`endif
      if (ZERO_REG && (rs_addr[p] == '0)) begin
        rs_data[p] = '0;
        rs_busy[p] = 1'b0;
      end
    end
  end

  assign rs1_data_o = rs_data[0];
  assign rs2_data_o = rs_data[1];
  assign rs1_busy_o = rs_busy[0];
  assign rs2_busy_o = rs_busy[1];

endmodule

// File: tb/tb_regbank_sb.sv
// Self-checking bench for regbank_sb: directed scenarios with literal expectations, then random traffic
// compared every cycle against an array-based reference model.
module tb_regbank_sb;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned NREGS = 32;
  localparam int unsigned AW    = $clog2(NREGS);

  logic            clk = 1'b0;
  logic            rst_n;
  logic [AW-1:0]   rs1_addr, rs2_addr, rd_addr, alloc_addr;
  logic [XLEN-1:0] rs1_data, rs2_data, data_in;
  logic            rs1_busy, rs2_busy, wr_en, alloc_en, alloc_ok, flush;
  logic [AW:0]     busy_count;

  int n_checks = 0;
  int n_errors = 0;

  logic [XLEN-1:0] m_regs [NREGS];
  bit              m_busy [NREGS];

  regbank_sb #(.XLEN(XLEN), .NREGS(NREGS), .ZERO_REG(1'b1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rs1_addr_i   (rs1_addr),
    .rs2_addr_i   (rs2_addr),
    .rs1_data_o   (rs1_data),
    .rs2_data_o   (rs2_data),
    .rs1_busy_o   (rs1_busy),
    .rs2_busy_o   (rs2_busy),
    .wr_en_i      (wr_en),
    .rd_addr_i    (rd_addr),
    .data_i       (data_in),
    .alloc_en_i   (alloc_en),
    .alloc_addr_i (alloc_addr),
    .alloc_ok_o   (alloc_ok),
    .flush_i      (flush),
    .busy_count_o (busy_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---- reference model ----
  function automatic bit m_ok(input logic [AW-1:0] a);
    return (a == 0) || !m_busy[a];
  endfunction

  function automatic logic [XLEN-1:0] m_rdata(input logic [AW-1:0] a);
    if (a == 0) return '0;
`ifdef REGBANK_BYPASS_EN
    if (wr_en && rd_addr == a) return data_in;
`endif
    return m_regs[a];
  endfunction

  function automatic bit m_rbusy(input logic [AW-1:0] a);
    if (a == 0) return 1'b0;
`ifdef REGBANK_BYPASS_EN
    if (wr_en && rd_addr == a) return alloc_en && m_ok(alloc_addr) && !flush && alloc_addr == a;
`endif
    return m_busy[a];
  endfunction

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < NREGS; i++) c += int'(m_busy[i]);
    return c;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < NREGS; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
  endtask

  // Applies the current inputs at a clock edge.
  task automatic m_edge();
    bit ok;
    ok = m_ok(alloc_addr);
    if (wr_en && rd_addr != 0) begin
      m_regs[rd_addr] = data_in;
      m_busy[rd_addr] = 1'b0;
    end
    if (flush) begin
      for (int i = 0; i < NREGS; i++) m_busy[i] = 1'b0;
    end else if (alloc_en && ok && alloc_addr != 0) begin
      m_busy[alloc_addr] = 1'b1;
    end
  endtask

  task automatic cmp_all();
    chk("rs1_data", 64'(rs1_data), 64'(m_rdata(rs1_addr)));
    chk("rs2_data", 64'(rs2_data), 64'(m_rdata(rs2_addr)));
    chk("rs1_busy", 64'(rs1_busy), 64'(m_rbusy(rs1_addr)));
    chk("rs2_busy", 64'(rs2_busy), 64'(m_rbusy(rs2_addr)));
    chk("alloc_ok", 64'(alloc_ok), 64'(m_ok(alloc_addr)));
    chk("busy_count", 64'(busy_count), 64'(m_count()));
  endtask

  // Drive one cycle of inputs, compare mid-cycle, then clock both DUT and model.
  task automatic step(input bit we, input logic [AW-1:0] rd, input logic [XLEN-1:0] d,
                      input bit ae, input logic [AW-1:0] aa, input bit fl,
                      input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    wr_en = we; rd_addr = rd; data_in = d;
    alloc_en = ae; alloc_addr = aa; flush = fl;
    rs1_addr = a1; rs2_addr = a2;
    #2;
    cmp_all();
    @(posedge clk);
    m_edge();
    #1;
  endtask

  task automatic idle(input logic [AW-1:0] a1, input logic [AW-1:0] a2, input logic [AW-1:0] aa);
    wr_en = 1'b0; alloc_en = 1'b0; flush = 1'b0;
    rs1_addr = a1; rs2_addr = a2; alloc_addr = aa;
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    m_reset();
    idle(5, 0, 0);
    data_in = '0; rd_addr = '0;
    chk("reset_count", 64'(busy_count), 64'd0);
    chk("reset_alloc_ok", 64'(alloc_ok), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Asynchronous reset clears state without a clock edge.
    step(1, 5, 32'hDEADBEEF, 1, 5, 0, 5, 5);
    idle(5, 5, 5);
    chk("r5_written", 64'(rs1_data), 64'hDEADBEEF);
    chk("r5_busy_pre", 64'(rs1_busy), 64'd1);
    rst_n = 1'b0;
    m_reset();
    #1;
    chk("async_rst_data", 64'(rs1_data), 64'd0);
    chk("async_rst_busy", 64'(rs1_busy), 64'd0);
    chk("async_rst_count", 64'(busy_count), 64'd0);
    chk("async_rst_ok", 64'(alloc_ok), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Alloc then writeback.
    step(0, 0, 0, 1, 7, 0, 7, 0);
    idle(7, 0, 7);
    chk("alloc7_busy", 64'(rs1_busy), 64'd1);
    chk("alloc7_count", 64'(busy_count), 64'd1);
    step(1, 7, 32'h12345678, 0, 0, 0, 7, 0);
    idle(7, 0, 7);
    chk("wb7_data", 64'(rs1_data), 64'h12345678);
    chk("wb7_busy", 64'(rs1_busy), 64'd0);
    chk("wb7_count", 64'(busy_count), 64'd0);

    // Double alloc is refused.
    step(0, 0, 0, 1, 3, 0, 3, 0);
    idle(3, 0, 3);
    chk("dbl_ok", 64'(alloc_ok), 64'd0);
    step(0, 0, 0, 1, 3, 0, 3, 0);
    chk("dbl_count", 64'(busy_count), 64'd1);
    step(1, 3, 32'h33, 0, 0, 0, 3, 0);

    // Zero register.
    step(0, 0, 0, 1, 0, 0, 0, 0);
    chk("r0_alloc_count", 64'(busy_count), 64'd0);
    step(1, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 0);
    idle(0, 0, 0);
    chk("r0_data", 64'(rs1_data), 64'd0);
    chk("r0_ok", 64'(alloc_ok), 64'd1);

    // Simultaneous write and alloc.
    step(0, 0, 0, 1, 9, 0, 9, 4);
    step(1, 9, 32'hA5, 1, 4, 0, 9, 4);
    idle(9, 4, 0);
    chk("sim_busy9", 64'(rs1_busy), 64'd0);
    chk("sim_busy4", 64'(rs2_busy), 64'd1);
    chk("sim_count", 64'(busy_count), 64'd1);
    step(1, 2, 32'hA5, 1, 2, 0, 2, 0);
    idle(2, 0, 0);
    chk("same_data", 64'(rs1_data), 64'hA5);
    chk("same_busy", 64'(rs1_busy), 64'd1);
    chk("same_count", 64'(busy_count), 64'd2);

    // Flush: release r4/r2, allocate r1..r3, then flush with alloc r4 and write r1.
    step(1, 4, 32'h4, 0, 0, 0, 0, 0);
    step(1, 2, 32'h2, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1, 0, 0, 0);
    step(0, 0, 0, 1, 2, 0, 0, 0);
    step(0, 0, 0, 1, 3, 0, 0, 0);
    chk("pre_flush_count", 64'(busy_count), 64'd3);
    step(1, 1, 32'h77, 1, 4, 1, 1, 4);
    idle(1, 4, 0);
    chk("flush_count", 64'(busy_count), 64'd0);
    chk("flush_r1", 64'(rs1_data), 64'h77);
    chk("flush_busy1", 64'(rs1_busy), 64'd0);
    chk("flush_busy4", 64'(rs2_busy), 64'd0);

    // Forwarding behaviour on r6 (previously 0).
    wr_en = 1'b1; rd_addr = 6; data_in = 32'hCAFE; rs2_addr = 6;
    #1;
`ifdef REGBANK_BYPASS_EN
    chk("bypass_same", 64'(rs2_data), 64'hCAFE);
`else
    chk("bypass_same", 64'(rs2_data), 64'h0);
`endif
    step(1, 6, 32'hCAFE, 0, 0, 0, 0, 6);
    idle(0, 6, 0);
    chk("bypass_next", 64'(rs2_data), 64'hCAFE);

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      step(bit'($urandom_range(0, 1)), AW'($urandom_range(0, NREGS - 1)), $urandom(),
           bit'($urandom_range(0, 1)), AW'($urandom_range(0, NREGS - 1)),
           ($urandom_range(0, 15) == 0),
           AW'($urandom_range(0, NREGS - 1)), AW'($urandom_range(0, NREGS - 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/regbank_sb.md
# regbank_sb

Parametrised integer register bank with two combinational read ports, one write port and an integrated scoreboard of pending-write (busy) bits for pipeline hazard detection. It sits between decode/issue, which reads operands and allocates destinations, and writeback, which commits results and releases them. It generalises the fixed 32x32 register file in width and depth. It adds asynchronous clear, optional write-to-read forwarding and producer tracking.

## Interface
- XLEN, 32, data width in bits (>=1)
- NREGS, 32, number of registers; power of two, >=2; address width AW = $clog2(NREGS) (localparam)
- ZERO_REG, 1, 1: register 0 reads 0 and ignores writes/allocations; 0: register 0 is ordinary
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- rs1_addr_i  input  AW  read port 1 address
- rs2_addr_i  input  AW  read port 2 address
- rs1_data_o  output  XLEN  read port 1 data
- rs2_data_o  output  XLEN  read port 2 data
- rs1_busy_o  output  1  rs1 register has an outstanding producer
- rs2_busy_o  output  1  rs2 register has an outstanding producer
- wr_en_i  input  1  writeback strobe
- rd_addr_i  input  AW  writeback address
- data_i  input  XLEN  writeback data
- alloc_en_i  input  1  mark a destination as pending
- alloc_addr_i  input  AW  destination to mark
- alloc_ok_o  output  1  allocation request acceptable this cycle (combinational)
- flush_i  input  1  clear all busy bits
- busy_count_o  output  AW+1  number of busy registers (registered)

## Operation
- State: regs[NREGS] of XLEN bits, busy[NREGS], busy_count.
- Reset (rst_n=0, asynchronous): all regs = 0, all busy = 0, busy_count = 0; hence rs*_data_o = 0, rs*_busy_o = 0, alloc_ok_o = 1 while reset is held. Reset asserted mid-operation discards pending writes/allocations immediately.
- Write: wr_en_i at posedge writes data_i into regs[rd_addr_i] and clears busy[rd_addr_i]. A write to a non-busy register is legal; data updates, busy stays 0.
- Reads: rs*_data_o = regs[rs*_addr_i], rs*_busy_o = busy[rs*_addr_i], combinational.
- ZERO_REG=1: address 0 always reads data 0, busy 0. Writes and allocations to address 0 are dropped. alloc_ok_o=1 for address 0, but no state changes.
- alloc_ok_o = !busy[alloc_addr_i] (after the zero rule); independent of alloc_en_i.
- Allocation: alloc_en_i && alloc_ok_o sets busy[alloc_addr_i] at posedge. alloc_en_i with alloc_ok_o=0 is ignored (no state change).
- Same-cycle alloc and write to the same register: the write commits data, and the busy bit ends at 1 (new producer wins). alloc_ok_o is evaluated on the pre-edge busy, so a busy register being written back the same cycle is refused.
- flush_i: at posedge all busy bits cleared and busy_count = 0; any same-cycle allocation is discarded. A same-cycle write still commits data.
- busy_count: next = flush ? 0 : count + set - clr. Here set = accepted allocation, and clr = write to a busy register, excluding one whose busy bit is re-set by a same-register allocation. Always equals popcount(busy); never wraps (max NREGS).

## Timing
- Read latency 0 cycles (combinational from address and state).
- Write/alloc/flush effects visible at outputs 1 cycle after the sampling edge, unless forwarding applies (see Configuration).
- No handshake back-pressure on writeback; wr_en_i is always accepted.
- alloc_ok_o is valid in the same cycle as alloc_addr_i; issue logic must qualify alloc_en_i with it.

## Configuration
- REGBANK_BYPASS_EN defined: when wr_en_i && rd_addr_i == rs*_addr_i (and not zero-register-suppressed), rs*_data_o = data_i in the same cycle. In that case rs*_busy_o = 0, unless alloc_en_i accepted for that same address this cycle (then 1).
- Undefined: no forwarding. Reads return stored contents, and busy reflects registered state only. The written value appears the cycle after the write.

## Test plan
- Reset: drive rst_n=0 mid-stream after writing 0xDEADBEEF to r5 -> rs1_data_o(r5)=0, rs1_busy_o=0, busy_count_o=0 immediately, without waiting for a clk edge.
- Alloc/writeback: alloc r7; the next cycle write r7=0x12345678 -> busy[7]=1 and count=1 after the first edge; data 0x12345678, busy 0, count 0 after the second.
- Double alloc: alloc r3, then alloc r3 again -> second cycle alloc_ok_o=0, count stays 1. Alloc r0 with ZERO_REG=1 -> count stays 0, r0 reads 0 after a write of 0xFFFFFFFF.
- Simultaneous: with r9 busy, write r9=0xA5 and alloc r4 in the same cycle -> busy[9]=0, busy[4]=1, count unchanged at 1. Same-register alloc+write on a non-busy r2 -> data 0xA5, busy[2]=1, count +1.
- Flush: allocate r1, r2 and r3, then flush_i together with alloc r4 and write r1=0x77 -> all busy 0, count 0, r1=0x77.
- Bypass: write r6=0xCAFE with rs2_addr_i=6 -> with REGBANK_BYPASS_EN, rs2_data_o=0xCAFE in the same cycle. Without it, the old value shows that cycle and 0xCAFE the next.
